// File: rtl/alu_exec_if.sv
// Instruction-issue, ALU-operand and writeback bundle shared by the execute
// controller (slave) and whatever feeds it and hosts the ALU (master).
interface alu_exec_if;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_op;
    logic [2:0] in_rd;
    logic [2:0] in_rs1;
    logic [2:0] in_rs2;
    logic       in_imm_en;
    logic [7:0] in_imm;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;

    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       done;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
        input  alu_result,
        output in_ready, alu_a, alu_b, alu_op,
        output wb_valid, wb_rd, wb_data, done
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
        output alu_result,
        input  in_ready, alu_a, alu_b, alu_op,
        input  wb_valid, wb_rd, wb_data, done
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Single-issue execute controller: reads operands from an 8x8 register file,
// holds them on the ALU for EXEC_WAIT cycles, then writes the result back.
module alu_exec_ctrl #(
    parameter int EXEC_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    alu_exec_if.slave   bus,
    output logic        flag_zero,
    output logic [1:0]  flag_cmp,
    output logic        err_illegal,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_MUL = 6'b000010;
    localparam logic [5:0] OP_DIV = 6'b000011;
    localparam logic [5:0] OP_CMP = 6'b000100;
    localparam logic [5:0] OP_NOT = 6'b001000;
    localparam logic [5:0] OP_AND = 6'b001001;
    localparam logic [5:0] OP_OR  = 6'b001010;
    localparam logic [5:0] OP_XOR = 6'b001011;
    localparam logic [5:0] OP_NOP = 6'b010000;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP,
            OP_NOT, OP_AND, OP_OR, OP_XOR, OP_NOP: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;
    logic [5:0]      op_q, op_d;
    logic [2:0]      rd_q, rd_d;
    logic            we_q, we_d;
    logic            cmp_q, cmp_d;
    logic            ill_q, ill_d;
    logic [2:0]      wb_rd_q, wb_rd_d;
    logic [7:0]      wb_data_q, wb_data_d;
    logic [7:0][7:0] rf_q, rf_d;
    logic            fz_q, fz_d;
    logic [1:0]      fc_q, fc_d;
    logic            err_q, err_d;

    logic            in_ready, wb_valid, done;
    logic            legal;
    logic [7:0]      rs1_val, rs2_val;

    // r0 is never written, but mask it anyway so it reads zero by construction
    assign rs1_val = (bus.in_rs1 == 3'd0) ? 8'h00 : rf_q[bus.in_rs1];
    assign rs2_val = (bus.in_rs2 == 3'd0) ? 8'h00 : rf_q[bus.in_rs2];
    assign legal   = op_legal(bus.in_op);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rd_d      = rd_q;
        we_d      = we_q;
        cmp_d     = cmp_q;
        ill_d     = ill_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        rf_d      = rf_q;
        fz_d      = fz_q;
        fc_d      = fc_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        wb_valid  = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    a_d     = rs1_val;
                    b_d     = bus.in_imm_en ? bus.in_imm : rs2_val;
                    op_d    = legal ? bus.in_op : OP_NOP;
                    rd_d    = bus.in_rd;
                    we_d    = legal && (bus.in_op != OP_NOP) && (bus.in_rd != 3'd0);
                    cmp_d   = (bus.in_op == OP_CMP);
                    ill_d   = !legal;
                    cnt_d   = 4'(EXEC_WAIT - 1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    wb_data_d = cmp_q ? {6'b0, bus.alu_result[1:0]} : bus.alu_result;
                    wb_rd_d   = rd_q;
                    state_d   = S_WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WB: begin
                done     = 1'b1;
                wb_valid = we_q;
                if (we_q) begin
                    rf_d[rd_q] = wb_data_q;
                    fz_d       = (wb_data_q == 8'h00);
                end
                // compare to r0 still updates the compare flags
                if (cmp_q) fc_d  = wb_data_q[1:0];
                if (ill_q) err_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_NOP;
            rd_q      <= '0;
            we_q      <= 1'b0;
            cmp_q     <= 1'b0;
            ill_q     <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            rf_q      <= '0;
            fz_q      <= 1'b0;
            fc_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            cmp_q     <= cmp_d;
            ill_q     <= ill_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            rf_q      <= rf_d;
            fz_q      <= fz_d;
            fc_q      <= fc_d;
            err_q     <= err_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.alu_a    = a_q;
    assign bus.alu_b    = b_q;
    assign bus.alu_op   = op_q;
    assign bus.wb_valid = wb_valid;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.done     = done;

    assign flag_zero   = fz_q;
    assign flag_cmp    = fc_q;
    assign err_illegal = err_q;
    assign dbg_data    = (dbg_addr == 3'd0) ? 8'h00 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural ALU hanging off the bus.
module tb_alu_exec_ctrl;
    localparam int EW = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       flag_zero;
    logic [1:0] flag_cmp;
    logic       err_illegal;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int         lat;
        logic       wv;
        logic [2:0] wr;
        logic [7:0] wd;
        logic [7:0] a0;
        logic [7:0] b0;
        logic [5:0] op0;
        logic       hold;
    } res_t;

    alu_exec_if bus();

    alu_exec_ctrl #(.EXEC_WAIT(EW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flag_zero  (flag_zero),
        .flag_cmp   (flag_cmp),
        .err_illegal(err_illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // compare: a==b -> 0xFD, a<b -> 0xFE, a>b -> 0xFC
    always_comb begin
        case (bus.alu_op)
            6'b000000: bus.alu_result = 8'(bus.alu_a + bus.alu_b);
            6'b000001: bus.alu_result = 8'(bus.alu_a - bus.alu_b);
            6'b000010: bus.alu_result = 8'(bus.alu_a * bus.alu_b);
            6'b000011: bus.alu_result = (bus.alu_b == 8'h00) ? 8'hFF : bus.alu_a / bus.alu_b;
            6'b000100: bus.alu_result = (bus.alu_a == bus.alu_b) ? 8'hFD :
                                        (bus.alu_a <  bus.alu_b) ? 8'hFE : 8'hFC;
            6'b001000: bus.alu_result = ~bus.alu_a;
            6'b001001: bus.alu_result = bus.alu_a & bus.alu_b;
            6'b001010: bus.alu_result = bus.alu_a | bus.alu_b;
            6'b001011: bus.alu_result = bus.alu_a ^ bus.alu_b;
            default:   bus.alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    task automatic wait_ready(input string tag);
        int g = 0;
        while (!bus.in_ready && g < 30) begin
            @(posedge clk); #1; g++;
        end
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Issue one instruction, wait for its done pulse, then step into IDLE.
    task automatic run(input string tag, input logic [5:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic ie,
                       input logic [7:0] imm, output res_t r);
        wait_ready(tag);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm_en = ie;
        bus.in_imm    = imm;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        r.a0   = bus.alu_a;
        r.b0   = bus.alu_b;
        r.op0  = bus.alu_op;
        r.hold = 1'b1;
        r.lat  = 0;
        while (!bus.done && r.lat < 30) begin
            @(posedge clk); #1; r.lat++;
            if (bus.alu_a !== r.a0 || bus.alu_b !== r.b0 || bus.alu_op !== r.op0)
                r.hold = 1'b0;
        end
        r.wv = bus.wb_valid;
        r.wr = bus.wb_rd;
        r.wd = bus.wb_data;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_lat"}, 32'(r.lat), 32'(EW));
    endtask

    initial begin
        res_t r;
        int   n;
        logic rdy;
        logic seen;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_imm_en = 1'b0;
        bus.in_imm    = '0;
        dbg_addr      = '0;
        #12 rst = 1'b0;
        @(posedge clk); #1;

        chk("rst_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_alu_a",  32'(bus.alu_a),    32'h00);
        chk("rst_alu_b",  32'(bus.alu_b),    32'h00);
        chk("rst_alu_op", 32'(bus.alu_op),   32'b010000);
        chk("rst_wbv",    32'(bus.wb_valid), 32'd0);
        chk("rst_done",   32'(bus.done),     32'd0);
        chk("rst_wbrd",   32'(bus.wb_rd),    32'd0);
        chk("rst_wbdata", 32'(bus.wb_data),  32'h00);
        chk("rst_flags",  32'({flag_zero, flag_cmp, err_illegal}), 32'd0);

        // add r1 = r0 + 5
        run("add", 6'b000000, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, r);
        chk("add_a",   32'(r.a0),  32'h00);
        chk("add_b",   32'(r.b0),  32'h05);
        chk("add_op",  32'(r.op0), 32'b000000);
        chk("add_hold", 32'(r.hold), 32'd1);
        chk("add_wb",  32'({r.wv, r.wr, r.wd}), 32'({1'b1, 3'd1, 8'h05}));
        chk_rf("add_rf1", 3'd1, 8'h05);
        chk("add_fz",  32'(flag_zero), 32'd0);

        // sub r3 = 5 - 0x0A wraps to 0xFB
        run("sub", 6'b000001, 3'd3, 3'd1, 3'd0, 1'b1, 8'h0A, r);
        chk("sub_wb", 32'({r.wv, r.wr, r.wd}), 32'({1'b1, 3'd3, 8'hFB}));
        chk_rf("sub_rf3", 3'd3, 8'hFB);

        // xor r4 = r1 ^ r1 = 0 sets flag_zero
        run("xor", 6'b001011, 3'd4, 3'd1, 3'd1, 1'b0, 8'h00, r);
        chk("xor_b",  32'(r.b0), 32'h05);
        chk("xor_wb", 32'({r.wv, r.wr, r.wd}), 32'({1'b1, 3'd4, 8'h00}));
        chk("xor_fz", 32'(flag_zero), 32'd1);

        // compare 5 vs 9 -> model gives 0xFE
        run("cmp", 6'b000100, 3'd2, 3'd1, 3'd0, 1'b1, 8'h09, r);
        chk("cmp_wb", 32'({r.wv, r.wr, r.wd}), 32'({1'b1, 3'd2, 8'h02}));
        chk("cmp_fc", 32'(flag_cmp), 32'b10);
        chk("cmp_fz", 32'(flag_zero), 32'd0);
        chk_rf("cmp_rf2", 3'd2, 8'h02);

        // compare 5 vs 5 into r0 -> 0xFD, flags only
        run("cmp0", 6'b000100, 3'd0, 3'd1, 3'd0, 1'b1, 8'h05, r);
        chk("cmp0_wbv", 32'(r.wv), 32'd0);
        chk("cmp0_fc",  32'(flag_cmp), 32'b01);
        chk_rf("cmp0_rf0", 3'd0, 8'h00);

        run("nop", 6'b010000, 3'd6, 3'd1, 3'd0, 1'b1, 8'h01, r);
        chk("nop_wbv", 32'(r.wv), 32'd0);
        chk("nop_err", 32'(err_illegal), 32'd0);
        chk_rf("nop_rf6", 3'd6, 8'h00);

        run("ill", 6'b111111, 3'd5, 3'd1, 3'd0, 1'b1, 8'h01, r);
        chk("ill_wbv", 32'(r.wv), 32'd0);
        chk("ill_op",  32'(r.op0), 32'b010000);
        chk("ill_err", 32'(err_illegal), 32'd1);
        chk_rf("ill_rf5", 3'd5, 8'h00);

        // back-to-back with in_valid held: r6 = 5+0x10, then r7 = r6+1
        wait_ready("b2b");
        bus.in_valid  = 1'b1;
        bus.in_op     = 6'b000000;
        bus.in_rd     = 3'd6;
        bus.in_rs1    = 3'd1;
        bus.in_imm_en = 1'b1;
        bus.in_imm    = 8'h10;
        @(posedge clk); #1;
        bus.in_rd  = 3'd7;
        bus.in_rs1 = 3'd6;
        bus.in_imm = 8'h01;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 30) begin
            rdy = bus.in_ready;
            @(posedge clk); #1; n++;
        end
        bus.in_valid = 1'b0;
        chk("b2b_gap", 32'(n), 32'(EW + 2));
        chk("b2b_a",   32'(bus.alu_a), 32'h15);
        chk("b2b_b",   32'(bus.alu_b), 32'h01);
        n = 0;
        while (!bus.done && n < 30) begin
            @(posedge clk); #1; n++;
        end
        chk("b2b_lat", 32'(n), 32'(EW));
        chk("b2b_wb",  32'({bus.wb_valid, bus.wb_rd, bus.wb_data}), 32'({1'b1, 3'd7, 8'h16}));
        @(posedge clk); #1;
        chk("b2b_err", 32'(err_illegal), 32'd1);

        // reset during EXEC of add r5
        bus.in_valid  = 1'b1;
        bus.in_op     = 6'b000000;
        bus.in_rd     = 3'd5;
        bus.in_rs1    = 3'd1;
        bus.in_imm_en = 1'b1;
        bus.in_imm    = 8'h03;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("mid_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_ready",  32'(bus.in_ready), 32'd1);
        chk("mid_alu",    32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'({8'h00, 8'h00, 6'b010000}));
        chk("mid_wb",     32'({bus.wb_valid, bus.done, bus.wb_rd, bus.wb_data}), 32'd0);
        chk("mid_flags",  32'({flag_zero, flag_cmp, err_illegal}), 32'd0);
        chk_rf("mid_rf1", 3'd1, 8'h00);
        seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.wb_valid || bus.done) seen = 1'b1;
        end
        chk("post_nowb",  32'(seen), 32'd0);
        chk("post_ready", 32'(bus.in_ready), 32'd1);
        chk_rf("post_rf5", 3'd5, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
